// File: rtl/encoder_4x2_seq.sv
// rtl/encoder_4x2_seq.sv - sequential priority encoder: pending request mask issued as binary codes over valid/ready
module encoder_4x2_seq #(
    parameter int N  = 4,
    parameter int W  = 2,
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] code_o,
    output logic [N-1:0] pending_o,
    output logic         drop_o
);

    localparam logic [W-1:0] PTR_RESET = W'(N - 1);

    logic [N-1:0] pending;
    logic [W-1:0] ptr;
    logic [W-1:0] winner;
    logic [W-1:0] idx;
    logic         load;
    logic [N-1:0] load_mask;

    // Winner is chosen from the registered mask only; this cycle's req never competes.
    always_comb begin
        winner = '0;
        idx    = '0;
        if (RR == 0) begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) winner = W'(i);
            end
        end else begin
            // Walk from the farthest candidate back to ptr+1 so the nearest one wins;
            // k=N wraps to ptr itself, which therefore has the lowest priority.
            for (int k = N; k >= 1; k--) begin
                idx = ptr + W'(k);
                if (pending[idx]) winner = idx;
            end
        end
    end

    assign load      = (!valid_o || ready_i) && (|pending);
    assign load_mask = load ? (N'(1) << winner) : '0;
    assign pending_o = pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            valid_o <= 1'b0;
            code_o  <= '0;
            drop_o  <= 1'b0;
            ptr     <= PTR_RESET;
        end else begin
            pending <= (pending & ~load_mask) | req;
            drop_o  <= |(req & pending & ~load_mask);
            if (load) begin
                code_o  <= winner;
                valid_o <= 1'b1;
                ptr     <= winner;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// tb/tb_encoder_4x2_seq.sv - directed and random checks of encoder_4x2_seq in fixed-priority and round-robin modes
module tb_encoder_4x2_seq;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         ready_i;

    logic         valid_fp, valid_rr;
    logic [W-1:0] code_fp, code_rr;
    logic [N-1:0] pend_fp, pend_rr;
    logic         drop_fp, drop_rr;

    int checks = 0;
    int errors = 0;

    // Reference state per mode: index 0 = fixed priority, 1 = round robin
    int m_pend  [2];
    int m_valid [2];
    int m_code  [2];
    int m_drop  [2];
    int m_ptr   [2];

    always #5 clk = ~clk;

    encoder_4x2_seq #(.N(N), .W(W), .RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .ready_i(ready_i),
        .valid_o(valid_fp), .code_o(code_fp), .pending_o(pend_fp), .drop_o(drop_fp)
    );

    encoder_4x2_seq #(.N(N), .W(W), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .ready_i(ready_i),
        .valid_o(valid_rr), .code_o(code_rr), .pending_o(pend_rr), .drop_o(drop_rr)
    );

    function automatic int pick(int p, int ptr, int rr);
        if (rr == 0) begin
            for (int i = N - 1; i >= 0; i--)
                if (((p >> i) & 1) == 1) return i;
        end else begin
            for (int d = 1; d <= N; d++)
                if (((p >> ((ptr + d) % N)) & 1) == 1) return (ptr + d) % N;
        end
        return 0;
    endfunction

    task automatic model_edge(int r, int rdy, int rstn);
        for (int m = 0; m < 2; m++) begin
            if (rstn == 0) begin
                m_pend[m] = 0; m_valid[m] = 0; m_code[m] = 0; m_drop[m] = 0; m_ptr[m] = N - 1;
            end else begin
                int w;
                int mask;
                bit ld;
                ld   = (m_valid[m] == 0 || rdy == 1) && m_pend[m] != 0;
                w    = pick(m_pend[m], m_ptr[m], m);
                mask = ld ? (1 << w) : 0;
                m_drop[m] = ((r & m_pend[m] & ~mask) != 0) ? 1 : 0;
                m_pend[m] = (m_pend[m] & ~mask) | r;
                if (ld) begin
                    m_code[m] = w; m_valid[m] = 1; m_ptr[m] = w;
                end else if (m_valid[m] == 1 && rdy == 1) begin
                    m_valid[m] = 0;
                end
            end
        end
    endtask

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("fp_valid", int'(valid_fp), m_valid[0]);
        chk("fp_code",  int'(code_fp),  m_code[0]);
        chk("fp_pend",  int'(pend_fp),  m_pend[0]);
        chk("fp_drop",  int'(drop_fp),  m_drop[0]);
        chk("rr_valid", int'(valid_rr), m_valid[1]);
        chk("rr_code",  int'(code_rr),  m_code[1]);
        chk("rr_pend",  int'(pend_rr),  m_pend[1]);
        chk("rr_drop",  int'(drop_rr),  m_drop[1]);
    endtask

    task automatic step(int r, int rdy, int rstn);
        req     = N'(r);
        ready_i = rdy[0];
        rst_n   = rstn[0];
        @(posedge clk);
        model_edge(r, rdy, rstn);
        #1;
        chk_model();
    endtask

    initial begin
        req = '0; ready_i = 1'b0; rst_n = 1'b0;
        #2;

        // 1: reset ignores requests
        step(4'b1111, 1, 0);
        chk("t1_valid", int'(valid_fp), 0);
        chk("t1_pend",  int'(pend_fp),  0);
        step(4'b1111, 1, 0);
        chk("t1_code",  int'(code_fp),  0);
        chk("t1_drop",  int'(drop_fp),  0);
        step(0, 1, 1);

        // 2: single request latency
        step(4'b0100, 1, 1);
        chk("t2_pend_k1",  int'(pend_fp), 4);
        chk("t2_valid_k1", int'(valid_fp), 0);
        step(0, 1, 1);
        chk("t2_valid_k2", int'(valid_fp), 1);
        chk("t2_code_k2",  int'(code_fp), 2);
        chk("t2_pend_k2",  int'(pend_fp), 0);
        step(0, 1, 1);
        chk("t2_idle", int'(valid_fp), 0);

        // 3: fixed priority drains 3,1,0
        step(4'b1011, 1, 1);
        step(0, 1, 1); chk("t3_code3", int'(code_fp), 3);
        step(0, 1, 1); chk("t3_code1", int'(code_fp), 1);
        step(0, 1, 1); chk("t3_code0", int'(code_fp), 0);
        step(0, 1, 1); chk("t3_idle",  int'(valid_fp), 0);

        // 4: stall, re-request, then merge-drop
        step(4'b0001, 0, 1);
        step(0, 0, 1);
        chk("t4_held_code",  int'(code_fp), 0);
        chk("t4_held_valid", int'(valid_fp), 1);
        step(4'b0001, 0, 1);
        chk("t4_pend", int'(pend_fp), 1);
        chk("t4_nodrop", int'(drop_fp), 0);
        step(4'b0001, 0, 1);
        chk("t4_drop", int'(drop_fp), 1);
        step(0, 0, 1);
        chk("t4_drop_pulse", int'(drop_fp), 0);
        step(0, 1, 1);
        chk("t4_second_code", int'(code_fp), 0);
        chk("t4_second_valid", int'(valid_fp), 1);
        step(0, 1, 1);
        chk("t4_idle", int'(valid_fp), 0);

        // 5: round robin versus fixed priority from a fresh pointer
        step(0, 1, 0);
        step(4'b1111, 1, 1);
        step(0, 1, 1); chk("t5_rr0", int'(code_rr), 0); chk("t5_fp3", int'(code_fp), 3);
        step(0, 1, 1); chk("t5_rr1", int'(code_rr), 1);
        step(0, 1, 1); chk("t5_rr2", int'(code_rr), 2);
        step(4'b1001, 1, 1); chk("t5_rr3", int'(code_rr), 3);
        step(0, 1, 1); chk("t5_rr_b0", int'(code_rr), 0); chk("t5_fp_b3", int'(code_fp), 3);
        step(0, 1, 1); chk("t5_rr_b3", int'(code_rr), 3); chk("t5_fp_b0", int'(code_fp), 0);
        step(0, 1, 1);

        // 6: reset while stalled with work pending
        step(4'b0001, 0, 1);
        step(0, 0, 1);
        step(4'b1110, 0, 1);
        chk("t6_pend", int'(pend_fp), 14);
        chk("t6_held", int'(valid_fp), 1);
        step(0, 0, 0);
        chk("t6_rst_valid", int'(valid_fp), 0);
        chk("t6_rst_pend",  int'(pend_fp), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1);
            chk("t6_no_stale", int'(valid_fp | valid_rr), 0);
        end

        // Random traffic, including occasional resets
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 15)) & ((($urandom % 3) == 0) ? 15 : 0),
                 int'($urandom_range(0, 3) != 0),
                 int'(($urandom % 40) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
